// File: rtl/overlay_pkg.sv
// Shared types and colour constants for the overlay mixer.
// Geometry struct widths match the mixer's default coordinate and box widths.
package overlay_pkg;

  localparam int GEOM_COORD_W = 10;
  localparam int GEOM_BOX_W   = 12;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t RED    = 12'hF00;
  localparam rgb444_t GREEN  = 12'h0F0;
  localparam rgb444_t YELLOW = 12'hFF0;
  localparam rgb444_t BLACK  = 12'h000;

  typedef struct packed {
    logic [GEOM_COORD_W-1:0] aim_x;
    logic [GEOM_COORD_W-1:0] aim_y;
    logic [GEOM_BOX_W-1:0]   box_x_min;
    logic [GEOM_BOX_W-1:0]   box_x_max;
    logic [GEOM_BOX_W-1:0]   box_y_min;
    logic [GEOM_BOX_W-1:0]   box_y_max;
    logic                    detected;
  } tgt_geom_t;

endpackage

// File: rtl/overlay_hit_test.sv
// One-slot hit test: is the pixel on this target's box outline or crosshair.
// Purely combinational (0 cycles); no flow control.
module overlay_hit_test
  import overlay_pkg::*;
#(
  parameter int COORD_W = GEOM_COORD_W,
  parameter int BOX_W   = GEOM_BOX_W,
  parameter int AIM_LEN = 5,
  parameter int AIM_THK = 1
) (
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  tgt_geom_t          geom,
  output logic               on_box,
  output logic               on_aim
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0] LEN_E = EW'(AIM_LEN);
  localparam logic [EW-1:0] THK_E = EW'(AIM_THK);

  logic [EW-1:0] px, py, ax, ay;
  logic [EW-1:0] x_lo_len, x_hi_len, x_lo_thk, x_hi_thk;
  logic [EW-1:0] y_lo_len, y_hi_len, y_lo_thk, y_hi_thk;
  logic          x_in_len, x_in_thk, y_in_len, y_in_thk;

  assign px = {1'b0, x_pixel};
  assign py = {1'b0, y_pixel};
  assign ax = {1'b0, geom.aim_x};
  assign ay = {1'b0, geom.aim_y};

  // Lower window edges saturate at 0 so a crosshair near the left/top border never wraps.
  assign x_lo_len = (ax >= LEN_E) ? ax - LEN_E : '0;
  assign x_lo_thk = (ax >= THK_E) ? ax - THK_E : '0;
  assign y_lo_len = (ay >= LEN_E) ? ay - LEN_E : '0;
  assign y_lo_thk = (ay >= THK_E) ? ay - THK_E : '0;
  assign x_hi_len = ax + LEN_E;
  assign x_hi_thk = ax + THK_E;
  assign y_hi_len = ay + LEN_E;
  assign y_hi_thk = ay + THK_E;

  assign x_in_len = (px >= x_lo_len) && (px <= x_hi_len);
  assign x_in_thk = (px >= x_lo_thk) && (px <= x_hi_thk);
  assign y_in_len = (py >= y_lo_len) && (py <= y_hi_len);
  assign y_in_thk = (py >= y_lo_thk) && (py <= y_hi_thk);

  assign on_aim = geom.detected && ((y_in_thk && x_in_len) || (x_in_thk && y_in_len));

  logic [BOX_W-1:0] bx, by;
  logic             box_ok, in_x, in_y, on_row, on_col;

  assign bx     = BOX_W'(x_pixel);
  assign by     = BOX_W'(y_pixel);
  assign box_ok = (geom.box_x_min <= geom.box_x_max) && (geom.box_y_min <= geom.box_y_max);
  assign in_x   = (bx >= geom.box_x_min) && (bx <= geom.box_x_max);
  assign in_y   = (by >= geom.box_y_min) && (by <= geom.box_y_max);
  assign on_row = ((by == geom.box_y_min) || (by == geom.box_y_max)) && in_x;
  assign on_col = ((bx == geom.box_x_min) || (bx == geom.box_x_max)) && in_y;
  assign on_box = geom.detected && box_ok && (on_row || on_col);

endmodule

// File: rtl/overlay_mixer_pipe.sv
// Box/crosshair overlay mixer with per-frame geometry shadows and a blinking selected box.
// Latency 2 cycles de_in->de_out; streaming pixel path with no backpressure.
module overlay_mixer_pipe
  import overlay_pkg::*;
#(
  parameter int N_TGT        = 16,
  parameter int COORD_W      = 10,
  parameter int BOX_W        = 12,
  parameter int AIM_LEN      = 5,
  parameter int AIM_THK      = 1,
  parameter int BLINK_FRAMES = 16,
  localparam int IDX_W       = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     de_in,
  input  logic [COORD_W-1:0]       x_pixel,
  input  logic [COORD_W-1:0]       y_pixel,
  input  logic [11:0]              img_bg,
  input  logic [N_TGT*COORD_W-1:0] aim_x_all,
  input  logic [N_TGT*COORD_W-1:0] aim_y_all,
  input  logic [N_TGT-1:0]         aim_detected_all,
  input  logic [N_TGT*BOX_W-1:0]   box_x_min_all,
  input  logic [N_TGT*BOX_W-1:0]   box_x_max_all,
  input  logic [N_TGT*BOX_W-1:0]   box_y_min_all,
  input  logic [N_TGT*BOX_W-1:0]   box_y_max_all,
  input  logic                     sel_valid,
  input  logic [IDX_W-1:0]         sel_idx,
  input  logic                     target_off,
  output logic                     de_out,
  output logic [3:0]               r_port,
  output logic [3:0]               g_port,
  output logic [3:0]               b_port
);

  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  if (COORD_W != GEOM_COORD_W || BOX_W != GEOM_BOX_W || BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("overlay_mixer_pipe: unsupported parameter combination");
  end

  tgt_geom_t        geom_in [N_TGT];
  tgt_geom_t        geom_s  [N_TGT];
  logic             sel_valid_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             off_s;
  logic [BCW-1:0]   blink_cnt;
  logic             blink_phase;

  for (genvar k = 0; k < N_TGT; k++) begin : g_unpack
    assign geom_in[k] = '{
      aim_x:     aim_x_all[k*COORD_W +: COORD_W],
      aim_y:     aim_y_all[k*COORD_W +: COORD_W],
      box_x_min: box_x_min_all[k*BOX_W +: BOX_W],
      box_x_max: box_x_max_all[k*BOX_W +: BOX_W],
      box_y_min: box_y_min_all[k*BOX_W +: BOX_W],
      box_y_max: box_y_max_all[k*BOX_W +: BOX_W],
      detected:  aim_detected_all[k]
    };
  end

  // Geometry is only sampled at frame_start so a frame never shows a half-updated overlay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TGT; k++) geom_s[k] <= '0;
      sel_valid_s <= 1'b0;
      sel_idx_s   <= '0;
      off_s       <= 1'b0;
    end else if (frame_start) begin
      geom_s      <= geom_in;
      sel_valid_s <= sel_valid;
      sel_idx_s   <= sel_idx;
      off_s       <= target_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [N_TGT-1:0] on_box, on_aim;

  for (genvar k = 0; k < N_TGT; k++) begin : g_hit
    overlay_hit_test #(
      .COORD_W (COORD_W),
      .BOX_W   (BOX_W),
      .AIM_LEN (AIM_LEN),
      .AIM_THK (AIM_THK)
    ) u_hit (
      .x_pixel (x_pixel),
      .y_pixel (y_pixel),
      .geom    (geom_s[k]),
      .on_box  (on_box[k]),
      .on_aim  (on_aim[k])
    );
  end

  // Indices with no matching slot (only possible when N_TGT is not a power of two) select nothing.
  logic sel_on;
  always_comb begin
    sel_on = 1'b0;
    for (int k = 0; k < N_TGT; k++) begin
      if (sel_idx_s == IDX_W'(k)) sel_on = on_box[k] & geom_s[k].detected;
    end
  end

  // Shadow-derived flags ride along with the pixel so a mid-pipe frame_start cannot affect it.
  logic [N_TGT-1:0] box_s1, aim_s1;
  logic             de_s1, off_s1, sel_s1, phase_s1;
  rgb444_t          bg_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_s1   <= '0;
      aim_s1   <= '0;
      de_s1    <= 1'b0;
      off_s1   <= 1'b0;
      sel_s1   <= 1'b0;
      phase_s1 <= 1'b0;
      bg_s1    <= BLACK;
    end else begin
      box_s1   <= on_box;
      aim_s1   <= on_aim;
      de_s1    <= de_in;
      off_s1   <= off_s;
      sel_s1   <= sel_valid_s & sel_on;
      phase_s1 <= blink_phase;
      bg_s1    <= img_bg;
    end
  end

  rgb444_t mix;
  always_comb begin
    mix = BLACK;
    if (!de_s1)                   mix = BLACK;
    else if (off_s1)              mix = bg_s1;
    else if (|aim_s1)             mix = RED;
    else if (sel_s1 && phase_s1)  mix = YELLOW;
    else if (|box_s1)             mix = GREEN;
    else                          mix = bg_s1;
  end

  rgb444_t rgb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= BLACK;
      de_out <= 1'b0;
    end else begin
      rgb_q  <= mix;
      de_out <= de_s1;
    end
  end

  assign r_port = rgb_q[11:8];
  assign g_port = rgb_q[7:4];
  assign b_port = rgb_q[3:0];

endmodule

// File: tb/tb_overlay_mixer_pipe.sv
// Scoreboard bench for overlay_mixer_pipe (BLINK_FRAMES=2): expected {de_out,rgb} queued at drive time.
module tb_overlay_mixer_pipe;

  localparam int N  = 16;
  localparam int CW = 10;
  localparam int BW = 12;
  localparam logic [11:0] C_RED = 12'hF00, C_GRN = 12'h0F0, C_YEL = 12'hFF0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_start = 1'b0;
  logic            de_in = 1'b0;
  logic [CW-1:0]   x_pixel = '0;
  logic [CW-1:0]   y_pixel = '0;
  logic [11:0]     img_bg = '0;
  logic [N*CW-1:0] aim_x_all = '0;
  logic [N*CW-1:0] aim_y_all = '0;
  logic [N-1:0]    aim_detected_all = '0;
  logic [N*BW-1:0] box_x_min_all = '0;
  logic [N*BW-1:0] box_x_max_all = '0;
  logic [N*BW-1:0] box_y_min_all = '0;
  logic [N*BW-1:0] box_y_max_all = '0;
  logic            sel_valid = 1'b0;
  logic [3:0]      sel_idx = '0;
  logic            target_off = 1'b0;
  logic            de_out;
  logic [3:0]      r_port, g_port, b_port;

  overlay_mixer_pipe #(.BLINK_FRAMES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .de_in            (de_in),
    .x_pixel          (x_pixel),
    .y_pixel          (y_pixel),
    .img_bg           (img_bg),
    .aim_x_all        (aim_x_all),
    .aim_y_all        (aim_y_all),
    .aim_detected_all (aim_detected_all),
    .box_x_min_all    (box_x_min_all),
    .box_x_max_all    (box_x_max_all),
    .box_y_min_all    (box_y_min_all),
    .box_y_max_all    (box_y_max_all),
    .sel_valid        (sel_valid),
    .sel_idx          (sel_idx),
    .target_off       (target_off),
    .de_out           (de_out),
    .r_port           (r_port),
    .g_port           (g_port),
    .b_port           (b_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int          due_q[$];
  logic [12:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outv();
    return {de_out, r_port, g_port, b_port};
  endfunction

  task automatic set_slot(input int k, input int ax, input int ay, input int x0, input int x1,
                          input int y0, input int y1, input logic det);
    aim_x_all[k*CW +: CW]     = CW'(ax);
    aim_y_all[k*CW +: CW]     = CW'(ay);
    box_x_min_all[k*BW +: BW] = BW'(x0);
    box_x_max_all[k*BW +: BW] = BW'(x1);
    box_y_min_all[k*BW +: BW] = BW'(y0);
    box_y_max_all[k*BW +: BW] = BW'(y1);
    aim_detected_all[k]       = det;
  endtask

  task automatic pix(input logic de, input int x, input int y, input logic [11:0] bg,
                     input logic fs, input logic [11:0] exp_rgb, input string tag);
    @(negedge clk);
    de_in = de;
    x_pixel = CW'(x);
    y_pixel = CW'(y);
    img_bg = bg;
    frame_start = fs;
    due_q.push_back(cyc + 2);
    exp_q.push_back(de ? {1'b1, exp_rgb} : 13'h0000);
    tag_q.push_back(tag);
  endtask

  task automatic pulse(input string tag);
    pix(1'b0, 0, 0, 12'hABC, 1'b1, 12'h000, tag);
  endtask

  task automatic drain();
    pix(1'b0, 0, 0, 12'hABC, 1'b0, 12'h000, "idle");
    for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
    check("drain_timeout", 32'(due_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      int          d;
      logic [12:0] e;
      string       t;
      @(posedge clk);
      cyc++;
      #1;
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        d = due_q.pop_front();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(outv()), 32'(e));
        if (d != cyc) check("sched", 32'(d), 32'(cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_de", 32'(de_out), 32'd0);
    check("rst_rgb", 32'(outv()), 32'd0);
    rst_n = 1'b1;

    // Geometry present but never latched: background only.
    set_slot(0, 500, 400, 10, 20, 10, 20, 1'b1);
    pix(1'b1, 10, 15, 12'h123, 1'b0, 12'h123, "pre_latch_box");
    pix(1'b0, 10, 15, 12'h123, 1'b0, 12'h000, "pre_latch_de0");
    pix(1'b1, 12, 10, 12'h456, 1'b0, 12'h456, "pre_latch_edge");

    set_slot(3, 600, 400, 100, 140, 50, 90, 1'b1);
    pulse("fs1");
    pix(1'b1, 100, 70, 12'h123, 1'b0, C_GRN,   "s3_left_edge");
    pix(1'b1, 101, 70, 12'h123, 1'b0, 12'h123, "s3_inside");
    pix(1'b1, 140, 90, 12'h234, 1'b0, C_GRN,   "s3_corner");
    pix(1'b1, 141, 90, 12'h234, 1'b0, 12'h234, "s3_outside");
    pix(1'b1, 10, 15, 12'h345, 1'b0, C_GRN,    "s0_left_edge");
    pix(1'b1, 15, 15, 12'h345, 1'b0, 12'h345,  "s0_inside");

    // Slots 5/6 carry crosshairs only (degenerate boxes).
    set_slot(5, 2, 3, 5, 4, 5, 4, 1'b1);
    set_slot(6, 120, 50, 9, 8, 9, 8, 1'b1);
    pulse("fs2");
    pix(1'b1, 0, 3, 12'h111, 1'b0, C_RED,      "aim_clamp_left");
    pix(1'b1, 1023, 3, 12'h111, 1'b0, 12'h111, "aim_no_wrap");
    pix(1'b1, 7, 3, 12'h111, 1'b0, C_RED,      "aim_right_end");
    pix(1'b1, 8, 3, 12'h111, 1'b0, 12'h111,    "aim_past_right");
    pix(1'b1, 2, 0, 12'h111, 1'b0, C_RED,      "aim_clamp_top");
    pix(1'b1, 2, 8, 12'h111, 1'b0, C_RED,      "aim_bottom_end");
    pix(1'b1, 2, 9, 12'h111, 1'b0, 12'h111,    "aim_past_bottom");
    pix(1'b1, 3, 4, 12'h111, 1'b0, C_RED,      "aim_thickness");
    pix(1'b1, 5, 5, 12'h222, 1'b0, 12'h222,    "degenerate_box");
    pix(1'b1, 120, 50, 12'h222, 1'b0, C_RED,   "aim_over_box");
    pix(1'b1, 126, 50, 12'h222, 1'b0, C_GRN,   "box_past_aim");

    // Blink with BLINK_FRAMES=2: phase is 1 after pulses 2,3 and 6,7.
    sel_valid = 1'b1;
    sel_idx = 4'd3;
    pulse("fs3");
    pix(1'b1, 100, 70, 12'h333, 1'b0, C_YEL, "blink_f3");
    pix(1'b1, 10, 15, 12'h333, 1'b0, C_GRN,  "unselected_box");
    pix(1'b1, 120, 50, 12'h333, 1'b0, C_RED, "aim_over_selected");
    pulse("fs4");
    pix(1'b1, 100, 70, 12'h333, 1'b0, C_GRN, "blink_f4");
    pulse("fs5");
    pix(1'b1, 100, 70, 12'h333, 1'b0, C_GRN, "blink_f5");
    pulse("fs6");
    pix(1'b1, 100, 70, 12'h333, 1'b0, C_YEL, "blink_f6");
    sel_idx = 4'd4;
    pulse("fs7");
    pix(1'b1, 100, 70, 12'h333, 1'b0, C_GRN, "sel_slot_undetected");
    aim_detected_all[3] = 1'b0;
    sel_idx = 4'd3;
    pulse("fs8");
    pix(1'b1, 100, 70, 12'h333, 1'b0, 12'h333, "sel_detected0");

    // Shadow hold and same-cycle frame_start.
    aim_detected_all[3] = 1'b1;
    sel_valid = 1'b0;
    pulse("fs9");
    pix(1'b1, 100, 70, 12'h444, 1'b0, C_GRN, "relatched");
    set_slot(3, 600, 400, 200, 240, 50, 90, 1'b1);
    pix(1'b1, 100, 70, 12'h444, 1'b0, C_GRN,   "hold_old_geom");
    pix(1'b1, 200, 70, 12'h444, 1'b0, 12'h444, "hold_new_absent");
    pix(1'b1, 100, 70, 12'h444, 1'b1, C_GRN,   "fs_same_cycle");
    pix(1'b1, 100, 70, 12'h444, 1'b0, 12'h444, "fs_next_old");
    pix(1'b1, 200, 70, 12'h444, 1'b0, C_GRN,   "fs_next_new");

    target_off = 1'b1;
    pulse("fs11");
    pix(1'b1, 200, 70, 12'h321, 1'b0, 12'h321, "off_box");
    pix(1'b1, 0, 3, 12'h321, 1'b0, 12'h321,    "off_aim");
    target_off = 1'b0;
    pix(1'b1, 120, 50, 12'h321, 1'b0, 12'h321, "off_held");
    drain();

    // Mid-line async reset with a visible pixel in flight.
    @(negedge clk);
    de_in = 1'b1;
    x_pixel = CW'(200);
    y_pixel = CW'(70);
    img_bg = 12'h5A5;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_de", 32'(de_out), 32'd1);
    check("pre_rst_rgb", 32'(outv()), 32'h1_5A5);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_de", 32'(de_out), 32'd0);
    check("async_rst_rgb", 32'(outv()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pix(1'b1, 200, 70, 12'h5A5, 1'b0, 12'h5A5, "post_rst_box");
    pix(1'b1, 0, 3, 12'h5A5, 1'b0, 12'h5A5,    "post_rst_aim");
    pulse("fs_post_rst");
    pix(1'b1, 200, 70, 12'h5A5, 1'b0, C_GRN,   "post_fs_box");
    pix(1'b1, 0, 3, 12'h5A5, 1'b0, C_RED,      "post_fs_aim");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overlay_mixer_pipe.md
Name: overlay_mixer_pipe

Overview:
- Registered, parametrised overlay mixer for the red-tracking VGA path. It sits between the camera frame buffer readout and the VGA output pins.
- Draws a bounding box and crosshair for up to N_TGT detected targets over the camera pixel.
- Target geometry is latched once per frame into shadow registers, so overlays never tear mid-frame.
- One selected target gets a blinking highlight box; the frame counter driving the blink is internal.

Parameters:
- N_TGT, 16, number of target slots.
- COORD_W, 10, pixel and aim coordinate width.
- BOX_W, 12, box coordinate width.
- AIM_LEN, 5, crosshair half-length in pixels.
- AIM_THK, 1, crosshair half-thickness in pixels.
- BLINK_FRAMES, 16, frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank; latches geometry.
- de_in  in  1  pixel valid for x_pixel, y_pixel, img_bg.
- x_pixel  in  COORD_W  current pixel x.
- y_pixel  in  COORD_W  current pixel y.
- img_bg  in  12  camera RGB444 pixel.
- aim_x_all  in  N_TGT*COORD_W  aim x, packed per slot.
- aim_y_all  in  N_TGT*COORD_W  aim y, packed per slot.
- aim_detected_all  in  N_TGT  slot valid.
- box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all  in  N_TGT*BOX_W each  box edges.
- sel_valid  in  1  highlight enable.
- sel_idx  in  clog2(N_TGT)  highlighted slot.
- target_off  in  1  suppress all overlays; sampled at frame_start.
- de_out  out  1  de_in delayed by 2.
- r_port, g_port, b_port  out  4 each  mixed colour.

Behaviour:
- Reset: every shadow register, pipeline register, blink_cnt and blink_phase clears to 0. de_out=0, r/g/b=0.
- Shadow latch on frame_start:
  - Copies all geometry, detected, sel_valid, sel_idx and target_off into shadow registers.
  - Between pulses the shadows hold; input changes have no effect.
  - Before the first frame_start, all detected shadows are 0, so output is background only.
- Blink counter:
  - blink_cnt increments on each frame_start.
  - When blink_cnt = BLINK_FRAMES-1, the same pulse wraps it to 0 and toggles blink_phase.
- Pipeline, fixed latency 2:
  - Stage 1 registers per-slot on_box[k] and on_aim[k], de, and img_bg.
  - Stage 2 registers the colour and de_out.
- Arithmetic:
  - Window edges are computed in COORD_W+1 bits.
  - aim-AIM_LEN and aim-AIM_THK clamp to 0 on underflow; there is no wrap-around.
  - Upper edges are not clamped.
  - Pixels are zero-extended to BOX_W for box compares; compares are unsigned and inclusive.
- Hit rules, evaluated only when detected[k]=1:
  - Box: the pixel lies on a box edge row (y = y_min or y_max, with x inside [x_min, x_max]) or on a box edge column (x = x_min or x_max, with y inside [y_min, y_max]).
  - Aim: horizontal bar |dy|<=AIM_THK and |dx|<=AIM_LEN; vertical bar |dx|<=AIM_THK and |dy|<=AIM_LEN.
  - A degenerate box (min > max) never hits.
- Selection:
  - sel_hit is true when sel_valid=1, detected[sel_idx]=1 and on_box[sel_idx]=1.
  - sel_idx >= N_TGT gives no highlight.
- Colour priority in stage 2:
  1. de=0 -> 12'h000.
  2. target_off shadow=1 -> img_bg.
  3. any on_aim -> 12'hF00.
  4. sel_hit with blink_phase=1 -> 12'hFF0.
  5. any on_box -> 12'h0F0. This covers the selected box when blink_phase=0.
  6. otherwise -> img_bg.
- Simultaneous events:
  - frame_start during de_in=1 is legal. Pixels already in the pipe use the old shadows; the next cycle's pixel uses the new ones.
  - Overlapping targets are OR-reduced.
- Reset mid-frame: outputs go to 0 immediately (async). After release, overlays stay off until the next frame_start.

Decomposition:
- Package overlay_pkg holds:
  - Colour constants RED, GREEN, YELLOW, BLACK.
  - typedef rgb444_t = logic [11:0].
  - typedef tgt_geom_t, a struct of aim_x, aim_y, box_x_min, box_x_max, box_y_min, box_y_max and detected.
- Sub-module overlay_hit_test evaluates one slot combinationally (pixel plus one tgt_geom_t -> on_box, on_aim). The top instantiates it N_TGT times in a generate loop.

Test Plan:
- No frame_start after reset; slot 0 detected with box (10,10)-(20,20); pixel (10,15) -> output equals img_bg, de_out follows de_in 2 cycles later.
- frame_start, then slot 3 box (100,50)-(140,90) -> pixel (100,70) gives 12'h0F0; (101,70) gives img_bg; (140,90) gives 12'h0F0.
- Aim at (2,3) with AIM_LEN=5 -> (0,3) gives 12'hF00 (clamp, no wrap); (1023,3) gives img_bg; (7,3) gives 12'hF00; (8,3) gives img_bg.
- sel_valid=1, sel_idx=3, BLINK_FRAMES=2 -> box pixel is 12'h0F0 for frames 0-1 and 12'hFF0 for frames 2-3; sel_idx=3 with detected[3]=0 -> no highlight.
- Change slot 3 geometry mid-frame without frame_start -> output unchanged until the next pulse. target_off=1 latched -> img_bg everywhere. Aim over box -> 12'hF00.
- Assert rst_n=0 mid-line -> r/g/b and de_out go to 0 asynchronously; after release, overlays are absent until frame_start.
